// File: rtl/dm_loader_pkg.sv
// Shared types and constants for the UART-to-data-memory image loader.
package dm_loader_pkg;

  localparam int DM_AW    = 13;
  localparam int DM_DW    = 16;
  localparam int DM_DEPTH = 8192;

  // Loader FSM: wait for start, collect low byte, collect high byte, write.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    WR   = 2'd3
  } state_e;

endpackage : dm_loader_pkg

// File: rtl/dm_loader_if.sv
// Bus bundle between the loader, its controller/UART side and the DM port.
// master: controller + UART RX side; slave: the loader itself.
interface dm_loader_if #(
  parameter int AW = dm_loader_pkg::DM_AW,
  parameter int DW = dm_loader_pkg::DM_DW
);

  // Control and UART byte stream
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_cnt;
  logic [7:0]    rx_byte;
  logic          rx_rdy;

  // Data-memory port and status
  logic [AW-1:0] dm_addr;
  logic          dm_we;
  logic          dm_re;
  logic [DW-1:0] dm_wdata;
  logic          busy;
  logic          done;
  logic [DW-1:0] chksum;

  modport master (
    output start, abort, base_addr, word_cnt, rx_byte, rx_rdy,
    input  dm_addr, dm_we, dm_re, dm_wdata, busy, done, chksum
  );

  modport slave (
    input  start, abort, base_addr, word_cnt, rx_byte, rx_rdy,
    output dm_addr, dm_we, dm_re, dm_wdata, busy, done, chksum
  );

endinterface : dm_loader_if

// File: rtl/dm_loader_chksum.sv
// ld_chksum: modulo-2^DW running sum of written words, with synchronous clear.
// Only instantiated when DM_LOADER_CHKSUM_EN is defined.
module ld_chksum
  import dm_loader_pkg::*;
#(
  parameter int DW = DM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_sum
);

  logic [DW-1:0] r_sum;

  // Accumulate each written word; clear wins because it only occurs in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule : ld_chksum

// File: rtl/dm_loader.sv
// dm_loader: packs little-endian byte pairs from the UART into DM words and
// writes them at consecutive (wrapping) addresses. All outputs are registered.
// Optional feature macro: DM_LOADER_CHKSUM_EN (running word checksum).
module dm_loader
  import dm_loader_pkg::*;
#(
  parameter int AW = DM_AW,
  parameter int DW = DM_DW
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_loader_if.slave  bus
);

  state_e        r_state;
  state_e        w_next;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_done;
  logic          r_busy;

  logic          w_accept;   // start taken in IDLE (any count)
  logic          w_ld_lo;    // capture rx_byte as low byte
  logic          w_ld_hi;    // capture rx_byte as high byte
  logic          w_adv;      // write happening this cycle: bump addr, drop count
  logic          w_done_nxt;
  logic          w_last;

  assign w_last = (r_cnt == (AW+1)'(1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control decode.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_ld_lo    = 1'b0;
    w_ld_hi    = 1'b0;
    w_adv      = 1'b0;
    w_done_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.word_cnt != '0) begin
            w_next = LO;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      LO: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (bus.rx_rdy) begin
          w_ld_lo = 1'b1;
          w_next  = HI;
        end
      end
      HI: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (bus.rx_rdy) begin
          w_ld_hi = 1'b1;
          w_next  = WR;
        end
      end
      WR: begin
        // The strobe is already high this cycle, so the write always completes.
        w_adv = 1'b1;
        if (w_last) begin
          w_next     = IDLE;
          w_done_nxt = !bus.abort;
        end else if (bus.abort) begin
          w_next = IDLE;
        end else if (bus.rx_rdy) begin
          w_ld_lo = 1'b1;
          w_next  = HI;
        end else begin
          w_next = LO;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Address/count counter, byte packer and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.base_addr;
        r_cnt  <= bus.word_cnt;
      end else if (w_adv) begin
        r_addr <= r_addr + 1'b1;   // wraps modulo 2^AW
        r_cnt  <= r_cnt - 1'b1;
      end
      if (w_ld_lo) begin
        r_wdata[7:0] <= bus.rx_byte;
      end
      if (w_ld_hi) begin
        r_wdata[DW-1:8] <= (DW-8)'(bus.rx_byte);
      end
      r_we   <= (w_next == WR);
      r_done <= w_done_nxt;
      r_busy <= (w_next != IDLE);
    end
  end

  assign bus.dm_addr  = r_addr;
  assign bus.dm_we    = r_we;
  assign bus.dm_re    = 1'b0;
  assign bus.dm_wdata = r_wdata;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

`ifdef DM_LOADER_CHKSUM_EN
  ld_chksum #(.DW(DW)) u_chksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_en   (r_we),
    .i_data (r_wdata),
    .o_sum  (bus.chksum)
  );
`else
  assign bus.chksum = '0;
`endif

endmodule : dm_loader

// File: tb/tb_dm_loader.sv
// Directed bench for dm_loader: hand-computed write/done/checksum expectations.
module tb_dm_loader;

  logic clk;
  logic rst_n;
  int   cyc;

  int   n_checks;
  int   n_fail;

  logic [31:0] wq[$];        // {3'b0, addr, data} per observed write
  int          done_cnt;
  int          busy_cnt;
  int          we_err;       // dm_we high on two consecutive cycles
  int          last_done_cyc;
  logic        prev_we;

  int          rdy_cyc;
  int          start_cyc;
  int          wq0;
  int          done0;
  int          busy0;

  dm_loader_if #(.AW(13), .DW(16)) bus ();

  dm_loader #(.AW(13), .DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor sampling mid-cycle on the negedge.
  always @(negedge clk) begin
    if (bus.dm_we) wq.push_back({3'b0, bus.dm_addr, bus.dm_wdata});
    if (bus.dm_we && prev_we) we_err++;
    prev_we = bus.dm_we;
    if (bus.done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (bus.busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wr_at(input int idx);
    if (idx < wq.size()) return wq[idx];
    return 32'hDEAD_DEAD;
  endfunction

  function automatic logic [15:0] exp_ck(input logic [15:0] v);
`ifdef DM_LOADER_CHKSUM_EN
    return v;
`else
    return (v & 16'h0000);
`endif
  endfunction

  // All stimulus tasks enter and leave 1 time unit after a posedge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [12:0] b, input logic [13:0] c);
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.word_cnt  = c;
    start_cyc     = cyc;
    idle(1);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte = b;
    bus.rx_rdy  = 1'b1;
    rdy_cyc     = cyc;
    idle(1);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    idle(1);
    bus.abort = 1'b0;
  endtask

  task automatic mark();
    wq0   = wq.size();
    done0 = done_cnt;
    busy0 = busy_cnt;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    done_cnt = 0; busy_cnt = 0; we_err = 0; last_done_cyc = -1; prev_we = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.word_cnt = '0;
    bus.rx_byte = '0; bus.rx_rdy = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    idle(2);

    // Reset values
    check("rst_addr",  32'(bus.dm_addr),  32'h0);
    check("rst_we",    32'(bus.dm_we),    32'h0);
    check("rst_re",    32'(bus.dm_re),    32'h0);
    check("rst_wdata", 32'(bus.dm_wdata), 32'h0);
    check("rst_busy",  32'(bus.busy),     32'h0);
    check("rst_done",  32'(bus.done),     32'h0);
    check("rst_ck",    32'(bus.chksum),   32'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic load: base 0x0100, count 2
    mark();
    do_start(13'h0100, 14'd2);
    check("basic_busy", 32'(bus.busy), 32'h1);
    send_byte(8'h34); idle(1);
    send_byte(8'h12); idle(1);
    send_byte(8'h78); idle(1);
    send_byte(8'h56);
    idle(4);
    check("basic_nwr",  32'(wq.size() - wq0), 32'd2);
    check("basic_wr0",  wr_at(wq0),     32'h0100_1234);
    check("basic_wr1",  wr_at(wq0 + 1), 32'h0101_5678);
    check("basic_done", 32'(done_cnt - done0), 32'd1);
    check("basic_dlat", 32'(last_done_cyc), 32'(rdy_cyc + 2));
    check("basic_idle", 32'(bus.busy), 32'h0);
    check("basic_ck",   32'(bus.chksum), 32'(exp_ck(16'h68AC)));

    // Address wrap: base 0x1FFF, count 2
    mark();
    do_start(13'h1FFF, 14'd2);
    send_byte(8'h01); idle(1);
    send_byte(8'h00); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'h00);
    idle(4);
    check("wrap_nwr", 32'(wq.size() - wq0), 32'd2);
    check("wrap_wr0", wr_at(wq0),     32'h1FFF_0001);
    check("wrap_wr1", wr_at(wq0 + 1), 32'h0000_0002);

    // Zero count: done next cycle, never busy, no write
    mark();
    do_start(13'h0123, 14'd0);
    idle(3);
    check("zero_done", 32'(done_cnt - done0), 32'd1);
    check("zero_dlat", 32'(last_done_cyc), 32'(start_cyc + 1));
    check("zero_busy", 32'(busy_cnt - busy0), 32'd0);
    check("zero_nwr",  32'(wq.size() - wq0), 32'd0);

    // Back-to-back bytes, count 3
    mark();
    do_start(13'h0200, 14'd3);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    idle(4);
    check("b2b_nwr",  32'(wq.size() - wq0), 32'd3);
    check("b2b_wr0",  wr_at(wq0),     32'h0200_2211);
    check("b2b_wr1",  wr_at(wq0 + 1), 32'h0201_4433);
    check("b2b_wr2",  wr_at(wq0 + 2), 32'h0202_6655);
    check("b2b_done", 32'(done_cnt - done0), 32'd1);
    check("b2b_we1",  32'(we_err), 32'd0);
    check("b2b_ck",   32'(bus.chksum), 32'(exp_ck(16'hCC99)));

    // Byte arriving during the last WR is dropped
    mark();
    do_start(13'h0210, 14'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(4);
    check("drop_nwr",  32'(wq.size() - wq0), 32'd1);
    check("drop_wr0",  wr_at(wq0), 32'h0210_BBAA);
    check("drop_done", 32'(done_cnt - done0), 32'd1);
    check("drop_busy", 32'(bus.busy), 32'h0);

    // Abort after 3 bytes of a 4-word load
    mark();
    do_start(13'h0300, 14'd4);
    send_byte(8'h01); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'h03); idle(1);
    do_abort();
    check("abort_busy", 32'(bus.busy), 32'h0);
    idle(4);
    check("abort_nwr",  32'(wq.size() - wq0), 32'd1);
    check("abort_wr0",  wr_at(wq0), 32'h0300_0201);
    check("abort_done", 32'(done_cnt - done0), 32'd0);
    check("abort_ck",   32'(bus.chksum), 32'(exp_ck(16'h0201)));

    // Reload after abort from a new base
    mark();
    do_start(13'h0400, 14'd1);
    send_byte(8'hEF); idle(1);
    send_byte(8'hBE);
    idle(4);
    check("reload_nwr",  32'(wq.size() - wq0), 32'd1);
    check("reload_wr0",  wr_at(wq0), 32'h0400_BEEF);
    check("reload_done", 32'(done_cnt - done0), 32'd1);
    check("reload_ck",   32'(bus.chksum), 32'(exp_ck(16'hBEEF)));

    // Async reset while in HI
    mark();
    do_start(13'h0500, 14'd2);
    send_byte(8'h99);
    check("hi_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(bus.busy),     32'h0);
    check("arst_we",    32'(bus.dm_we),    32'h0);
    check("arst_addr",  32'(bus.dm_addr),  32'h0);
    check("arst_wdata", 32'(bus.dm_wdata), 32'h0);
    check("arst_done",  32'(bus.done),     32'h0);
    check("arst_ck",    32'(bus.chksum),   32'h0);
    @(posedge clk); #1;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("arst_nwr",   32'(wq.size() - wq0), 32'd0);
    check("arst_idle",  32'(bus.busy), 32'h0);

    // start while busy is ignored
    mark();
    do_start(13'h0600, 14'd1);
    send_byte(8'h11);
    do_start(13'h0700, 14'd5);
    send_byte(8'h22);
    idle(4);
    check("ign_nwr",  32'(wq.size() - wq0), 32'd1);
    check("ign_wr0",  wr_at(wq0), 32'h0600_2211);
    check("ign_done", 32'(done_cnt - done0), 32'd1);
    check("ign_busy", 32'(bus.busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dm_loader
